sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like request arbiter with an in-order ID FIFO for routing data_ok back to masters.
// Define SRAM_ARB_RR_EN for round-robin grant; otherwise fixed priority (lowest index wins).
module sram_like_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int OT_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          m_req,
    input  logic [NUM_CH-1:0]          m_wr,
    input  logic [2*NUM_CH-1:0]        m_size,
    input  logic [(DATA_W/8)*NUM_CH-1:0] m_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]   m_addr,
    input  logic [DATA_W*NUM_CH-1:0]   m_wdata,
    output logic [NUM_CH-1:0]          m_addr_ok,
    output logic [NUM_CH-1:0]          m_data_ok,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [DATA_W/8-1:0]        s_wstrb,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,
    input  logic [DATA_W-1:0]          s_rdata,
    output logic                       err_unexp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = $clog2(OT_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] id_fifo [OT_DEPTH];
    logic             lock;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] grant;
    logic             hs;
    logic             pop;

`ifdef SRAM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    int               cand;

    always_comb begin
        arb_idx = rr_ptr;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_CH;
            if (!found && m_req[cand]) begin
                arb_idx = IDX_W'(cand);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + IDX_W'(1);
        end
    end
`else
    always_comb begin
        arb_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m_req[k]) arb_idx = IDX_W'(k);
        end
    end
`endif

    // Full is judged on the registered count, so a pop in the same cycle cannot reopen s_req.
    assign grant = lock ? lock_idx : arb_idx;
    assign s_req = (|m_req) && (count < CNT_W'(OT_DEPTH));
    assign hs    = s_req && s_addr_ok;
    assign pop   = s_data_ok && (count != '0);

    assign s_wr    = m_wr[grant];
    assign s_size  = m_size[2*int'(grant) +: 2];
    assign s_wstrb = m_wstrb[STRB_W*int'(grant) +: STRB_W];
    assign s_addr  = m_addr[ADDR_W*int'(grant) +: ADDR_W];
    assign s_wdata = m_wdata[DATA_W*int'(grant) +: DATA_W];
    assign m_rdata = s_rdata;

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (hs)  m_addr_ok[grant]           = 1'b1;
        if (pop) m_data_ok[id_fifo[rd_ptr]] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (hs) begin
                lock <= 1'b0;
            end else if (s_req) begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
            if (hs)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({hs, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (s_data_ok && (count == '0)) err_unexp <= 1'b1;
        end
    end

    // ID storage is data only; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (hs) id_fifo[wr_ptr] <= grant;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed testbench for sram_like_arbiter (NUM_CH=2, OT_DEPTH=4, 32-bit address/data).
module tb_sram_like_arbiter;

    logic        clk;
    logic        resetn;
    logic [1:0]  m_req;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [7:0]  m_wstrb;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_addr_ok;
    logic [1:0]  m_data_ok;
    logic [31:0] m_rdata;
    logic        s_req;
    logic        s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [31:0] s_rdata;
    logic        err_unexp;

    int total = 0;
    int bad   = 0;

    sram_like_arbiter #(
        .NUM_CH(2), .OT_DEPTH(4), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_req     = 2'b00;
        m_wr      = 2'b00;
        m_size    = 4'h0;
        m_wstrb   = 8'h00;
        m_addr    = 64'h0;
        m_wdata   = 64'h0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        #2;
        total++;
        if (s_req !== 1'b0) begin bad++; $display("FAIL reset_s_req: got %b want 0", s_req); end
        total++;
        if (m_addr_ok !== 2'b00) begin bad++; $display("FAIL reset_m_addr_ok: got %b want 00", m_addr_ok); end
        total++;
        if (m_data_ok !== 2'b00) begin bad++; $display("FAIL reset_m_data_ok: got %b want 00", m_data_ok); end
        total++;
        if (err_unexp !== 1'b0) begin bad++; $display("FAIL reset_err_unexp: got %b want 0", err_unexp); end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        total++;
        if (s_req !== 1'b0) begin bad++; $display("FAIL post_reset_s_req: got %b want 0", s_req); end
    endtask

    task automatic test_single_read();
        do_reset();
        m_req     = 2'b01;
        m_addr    = {32'h0000_0ABC, 32'h0000_0100};
        s_addr_ok = 1'b1;
        #1;
        total++;
        if (m_addr_ok !== 2'b01) begin bad++; $display("FAIL read_addr_ok: got %b want 01", m_addr_ok); end
        total++;
        if (s_addr !== 32'h0000_0100) begin bad++; $display("FAIL read_s_addr: got %h want 00000100", s_addr); end
        total++;
        if (s_wr !== 1'b0) begin bad++; $display("FAIL read_s_wr: got %b want 0", s_wr); end
        step();
        m_req     = 2'b00;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b1;
        s_rdata   = 32'hDEAD_BEEF;
        #1;
        total++;
        if (m_data_ok !== 2'b01) begin bad++; $display("FAIL read_data_ok: got %b want 01", m_data_ok); end
        total++;
        if (m_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_rdata: got %h want deadbeef", m_rdata); end
        total++;
        if (s_req !== 1'b0) begin bad++; $display("FAIL read_idle_s_req: got %b want 0", s_req); end
        step();
        s_data_ok = 1'b0;
        #1;
        total++;
        if (err_unexp !== 1'b0) begin bad++; $display("FAIL read_err_unexp: got %b want 0", err_unexp); end
    endtask

    task automatic test_arb_and_full();
        logic [1:0]  exp_g [4];
        logic [31:0] exp_a;
`ifdef SRAM_ARB_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        do_reset();
        m_req     = 2'b11;
        m_addr    = {32'h0000_00B0, 32'h0000_00A0};
        s_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_a = (exp_g[i] == 2'b01) ? 32'h0000_00A0 : 32'h0000_00B0;
            total++;
            if (m_addr_ok !== exp_g[i]) begin bad++; $display("FAIL arb_grant_%0d: got %b want %b", i, m_addr_ok, exp_g[i]); end
            total++;
            if (s_addr !== exp_a) begin bad++; $display("FAIL arb_addr_%0d: got %h want %h", i, s_addr, exp_a); end
            step();
        end
        #1;
        total++;
        if (s_req !== 1'b0) begin bad++; $display("FAIL full_s_req: got %b want 0", s_req); end
        total++;
        if (m_addr_ok !== 2'b00) begin bad++; $display("FAIL full_addr_ok: got %b want 00", m_addr_ok); end
        s_data_ok = 1'b1;
        s_rdata   = 32'h1111_0000;
        #1;
        total++;
        if (s_req !== 1'b0) begin bad++; $display("FAIL full_pop_s_req: got %b want 0", s_req); end
        total++;
        if (m_data_ok !== exp_g[0]) begin bad++; $display("FAIL full_pop_route: got %b want %b", m_data_ok, exp_g[0]); end
        step();
        s_data_ok = 1'b0;
        #1;
        total++;
        if (s_req !== 1'b1) begin bad++; $display("FAIL reopen_s_req: got %b want 1", s_req); end
        total++;
        if (m_addr_ok !== 2'b01) begin bad++; $display("FAIL reopen_grant: got %b want 01", m_addr_ok); end
        step();
        m_req     = 2'b00;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b1;
        exp_g[0]  = exp_g[1];
        exp_g[1]  = exp_g[2];
        exp_g[2]  = exp_g[3];
        exp_g[3]  = 2'b01;
        for (int i = 0; i < 4; i++) begin
            s_rdata = 32'h2222_0000 + 32'(i);
            #1;
            total++;
            if (m_data_ok !== exp_g[i]) begin bad++; $display("FAIL drain_route_%0d: got %b want %b", i, m_data_ok, exp_g[i]); end
            total++;
            if (m_rdata !== 32'h2222_0000 + 32'(i)) begin bad++; $display("FAIL drain_rdata_%0d: got %h want %h", i, m_rdata, 32'h2222_0000 + 32'(i)); end
            step();
        end
        s_data_ok = 1'b0;
        #1;
        total++;
        if (err_unexp !== 1'b0) begin bad++; $display("FAIL drain_err_unexp: got %b want 0", err_unexp); end
    endtask

    task automatic test_lock();
        do_reset();
        m_req     = 2'b10;
        m_wr      = 2'b10;
        m_size    = 4'b1000;
        m_wstrb   = 8'hF0;
        m_addr    = {32'h0000_0200, 32'h0000_0300};
        m_wdata   = {32'hCAFE_F00D, 32'h1234_5678};
        s_addr_ok = 1'b0;
        #1;
        total++;
        if (s_addr !== 32'h0000_0200) begin bad++; $display("FAIL lock_c1_addr: got %h want 00000200", s_addr); end
        total++;
        if ({s_wr, s_size, s_wstrb} !== 7'b1_10_1111) begin bad++; $display("FAIL lock_c1_fields: got %b want 1101111", {s_wr, s_size, s_wstrb}); end
        total++;
        if (s_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL lock_c1_wdata: got %h want cafef00d", s_wdata); end
        total++;
        if (m_addr_ok !== 2'b00) begin bad++; $display("FAIL lock_c1_addr_ok: got %b want 00", m_addr_ok); end
        step();
        m_req = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (s_addr !== 32'h0000_0200) begin bad++; $display("FAIL lock_hold_addr_%0d: got %h want 00000200", i, s_addr); end
            step();
        end
        s_addr_ok = 1'b1;
        #1;
        total++;
        if (m_addr_ok !== 2'b10) begin bad++; $display("FAIL lock_release_addr_ok: got %b want 10", m_addr_ok); end
        step();
        m_req = 2'b01;
        #1;
        total++;
        if (m_addr_ok !== 2'b01) begin bad++; $display("FAIL lock_next_addr_ok: got %b want 01", m_addr_ok); end
        total++;
        if (s_addr !== 32'h0000_0300) begin bad++; $display("FAIL lock_next_addr: got %h want 00000300", s_addr); end
        step();
        m_req     = 2'b00;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b1;
        #1;
        total++;
        if (m_data_ok !== 2'b10) begin bad++; $display("FAIL lock_ret0: got %b want 10", m_data_ok); end
        step();
        #1;
        total++;
        if (m_data_ok !== 2'b01) begin bad++; $display("FAIL lock_ret1: got %b want 01", m_data_ok); end
        step();
        s_data_ok = 1'b0;
    endtask

    task automatic test_unexpected();
        do_reset();
        s_data_ok = 1'b1;
        s_rdata   = 32'h5555_AAAA;
        #1;
        total++;
        if (m_data_ok !== 2'b00) begin bad++; $display("FAIL unexp_data_ok: got %b want 00", m_data_ok); end
        step();
        s_data_ok = 1'b0;
        #1;
        total++;
        if (err_unexp !== 1'b1) begin bad++; $display("FAIL unexp_flag: got %b want 1", err_unexp); end
        repeat (3) step();
        total++;
        if (err_unexp !== 1'b1) begin bad++; $display("FAIL unexp_sticky: got %b want 1", err_unexp); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_req     = 2'b01;
        m_addr    = {32'h0, 32'h0000_0400};
        s_addr_ok = 1'b1;
        repeat (2) step();
        clear_inputs();
        #1;
        resetn = 1'b0;
        #1;
        total++;
        if (dut.count !== 3'd0) begin bad++; $display("FAIL midreset_count: got %0d want 0", dut.count); end
        total++;
        if (err_unexp !== 1'b0) begin bad++; $display("FAIL midreset_err: got %b want 0", err_unexp); end
        step();
        resetn    = 1'b1;
        m_req     = 2'b01;
        m_addr    = {32'h0, 32'h0000_0500};
        s_addr_ok = 1'b1;
        #1;
        total++;
        if (m_addr_ok !== 2'b01) begin bad++; $display("FAIL midreset_reissue: got %b want 01", m_addr_ok); end
        step();
        clear_inputs();
        s_data_ok = 1'b1;
        #1;
        total++;
        if (m_data_ok !== 2'b01) begin bad++; $display("FAIL midreset_ret: got %b want 01", m_data_ok); end
        step();
        #1;
        total++;
        if (m_data_ok !== 2'b00) begin bad++; $display("FAIL midreset_extra_ret: got %b want 00", m_data_ok); end
        step();
        s_data_ok = 1'b0;
        #1;
        total++;
        if (err_unexp !== 1'b1) begin bad++; $display("FAIL midreset_extra_err: got %b want 1", err_unexp); end
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        test_reset();
        test_single_read();
        test_arb_and_full();
        test_lock();
        test_unexpected();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
